// File: rtl/mem_ctrl_port.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_port
// Description : Initiator port for a 64x32 single-port RAM with a registered
//               address. Accepts read/write bursts from a host over a
//               valid/ready handshake, drives the RAM address/write strobe/
//               write data, and returns read beats two cycles after each
//               address issue with a single-cycle valid strobe.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   mem_clk, mem_rst_n        clock, asynchronous active-low reset
//   host_req_valid/ready      burst request handshake
//   host_req_we/addr/len      burst direction, start address, beats-1
//   host_wr_data/valid/ready  write beat stream
//   host_rd_data/valid        registered read beats (no backpressure)
//   host_busy                 burst active or read pipeline non-empty
//   host_err                  one-cycle write-stall abort pulse
//   mc_address_mem            RAM address (registered)
//   mem_we, mem_data_in       RAM write strobe and data
//   mem_data_out              RAM read data, valid the cycle after address
// Build option:
//   MC_TIMEOUT_EN  when defined, a write burst stalled for TIMEOUT_CYC
//                  consecutive cycles is aborted and host_err pulses.
// ============================================================================
module mem_ctrl_port #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 6,
    parameter int LEN_W       = 3,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              mem_clk,
    input  logic              mem_rst_n,
    input  logic              host_req_valid,
    output logic              host_req_ready,
    input  logic              host_req_we,
    input  logic [ADDR_W-1:0] host_req_addr,
    input  logic [LEN_W-1:0]  host_req_len,
    input  logic [DATA_W-1:0] host_wr_data,
    input  logic              host_wr_valid,
    output logic              host_wr_ready,
    output logic [DATA_W-1:0] host_rd_data,
    output logic              host_rd_valid,
    output logic              host_busy,
    output logic              host_err,
    output logic [ADDR_W-1:0] mc_address_mem,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [ADDR_W-1:0]  addr_q,     addr_d;
    logic [LEN_W-1:0]   beats_q,    beats_d;
    logic               rd_pend_q,  rd_pend_d;
    logic [DATA_W-1:0]  rd_data_q,  rd_data_d;
    logic               rd_valid_q, rd_valid_d;

`ifdef MC_TIMEOUT_EN
    // Last stall count before the abort fires; the abort happens on the
    // cycle that would make the count reach TIMEOUT_CYC.
    localparam logic [4:0] C_STALL_LAST = 5'(TIMEOUT_CYC - 1);

    logic [4:0]         stall_q,    stall_d;
    logic               err_q,      err_d;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        beats_d    = beats_q;
        rd_pend_d  = 1'b0;
        // The pipeline stage after an issue captures RAM data; the stage
        // after that presents it to the host.
        rd_valid_d = rd_pend_q;
        rd_data_d  = rd_pend_q ? mem_data_out : rd_data_q;
`ifdef MC_TIMEOUT_EN
        stall_d    = 5'd0;
        err_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (host_req_valid) begin
                    addr_d  = host_req_addr;
                    beats_d = host_req_len;
                    state_d = host_req_we ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                if (host_wr_valid) begin
                    addr_d  = addr_q + 1'b1;
                    beats_d = beats_q - 1'b1;
                    if (beats_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
`ifdef MC_TIMEOUT_EN
                else if (stall_q == C_STALL_LAST) begin
                    // Abort; beats already written stay in the RAM.
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
`endif
            end
            ST_READ: begin
                // One address per cycle, never stalls.
                rd_pend_d = 1'b1;
                addr_d    = addr_q + 1'b1;
                beats_d   = beats_q - 1'b1;
                if (beats_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            beats_q    <= '0;
            rd_pend_q  <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
`ifdef MC_TIMEOUT_EN
            stall_q    <= 5'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beats_q    <= beats_d;
            rd_pend_q  <= rd_pend_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
`ifdef MC_TIMEOUT_EN
            stall_q    <= stall_d;
            err_q      <= err_d;
`endif
        end
    end

    assign host_req_ready = (state_q == ST_IDLE);
    assign host_wr_ready  = (state_q == ST_WRITE);
    // The RAM samples we/data on the same edge as the host handshake, so
    // these pass straight through while a write burst is active.
    assign mem_we         = (state_q == ST_WRITE) & host_wr_valid;
    assign mem_data_in    = (state_q == ST_WRITE) ? host_wr_data : '0;
    assign mc_address_mem = addr_q;
    assign host_rd_data   = rd_data_q;
    assign host_rd_valid  = rd_valid_q;
    assign host_busy      = (state_q != ST_IDLE) | rd_pend_q | rd_valid_q;

`ifdef MC_TIMEOUT_EN
    assign host_err = err_q;
`else
    // Write stalls are unbounded in this build; the limit parameter has no
    // effect and host_err never asserts for any legal TIMEOUT_CYC.
    assign host_err = (TIMEOUT_CYC < 0);
`endif

endmodule
`default_nettype wire
